// File: rtl/pg_stream_pkg.sv
// Shared stream-width helpers for the down-converter (fifo_serializer) and the planned up-converter.
package pg_stream_pkg;

  typedef enum logic {SER_EMPTY, SER_BUSY} ser_state_e;

  // Width of a chunk index for a din/dout width ratio.
  function automatic int unsigned chunk_cw(input int unsigned din, input int unsigned dout);
    return $clog2(din / dout);
  endfunction

endpackage

// File: rtl/fifo_serializer.sv
// Width down-converter: one DIN word in, DIN/DOUT DOUT-wide chunks out, LSB chunk first, last flagged.
// Optional SERIALIZE_LEN_EN adds din_len to trim the number of chunks emitted per word.
module fifo_serializer
  import pg_stream_pkg::*;
#(
  parameter int unsigned DIN  = 16,
  parameter int unsigned DOUT = 4,
  localparam int unsigned N   = DIN / DOUT,
  localparam int unsigned CW  = chunk_cw(DIN, DOUT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            din_ready,
  input  logic            din_valid,
  input  logic [DIN-1:0]  din_data,
`ifdef SERIALIZE_LEN_EN
  input  logic [CW-1:0]   din_len,
`endif
  input  logic            dout_ready,
  output logic            dout_valid,
  output logic [DOUT:0]   dout_data
);

  if ((DIN % DOUT) != 0 || (DIN / DOUT) < 2) begin : g_bad_cfg
    $error("fifo_serializer: DIN must be a multiple of DOUT with DIN/DOUT >= 2");
  end

  ser_state_e         r_state;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      r_lastidx;
  logic [DIN-1:0]     r_hold;

  logic               w_last;
  logic               w_dout_hs;
  logic               w_fin;
  logic               w_din_hs;
  logic [CW-1:0]      w_load_lastidx;

`ifdef SERIALIZE_LEN_EN
  // Out-of-range lengths emit the whole word rather than overrunning the hold register.
  assign w_load_lastidx = (32'(din_len) >= N) ? CW'(N - 1) : din_len;
`else
  assign w_load_lastidx = CW'(N - 1);
`endif

  assign dout_valid = (r_state == SER_BUSY);
  assign w_last     = (r_cnt == r_lastidx);
  assign dout_data  = {w_last, r_hold[r_cnt*DOUT +: DOUT]};

  assign w_dout_hs  = dout_valid & dout_ready;
  assign w_fin      = w_dout_hs & w_last;
  // Accepting on the final chunk handshake gives back-to-back words without a bubble.
  assign din_ready  = !rst & ((r_state == SER_EMPTY) | w_fin);
  assign w_din_hs   = din_valid & din_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SER_EMPTY;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        SER_EMPTY: begin
          if (w_din_hs) begin
            r_hold    <= din_data;
            r_lastidx <= w_load_lastidx;
            r_cnt     <= '0;
            r_state   <= SER_BUSY;
          end
        end
        SER_BUSY: begin
          if (w_fin) begin
            r_cnt <= '0;
            if (w_din_hs) begin
              r_hold    <= din_data;
              r_lastidx <= w_load_lastidx;
            end else begin
              r_state <= SER_EMPTY;
            end
          end else if (w_dout_hs) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= SER_EMPTY;
      endcase
    end
  end

endmodule
